// File: rtl/coord_plotter_if.sv
// Coordinate stream handshake between a generator (master) and the plotter (slave).
interface coord_plotter_if;
  logic               _in_valid;
  logic               _in_ready;
  logic signed [31:0] _in0;
  logic signed [31:0] _in1;
  logic               _in_last;

  modport master (output _in_valid, _in0, _in1, _in_last, input _in_ready);
  modport slave  (input _in_valid, _in0, _in1, _in_last, output _in_ready);
endinterface

// File: rtl/coord_plotter.sv
// Coordinate sink: clips (row, col) pairs into a 1-bit framebuffer, then scans it out row by row.
// Define COORD_PLOTTER_XOR_EN to make in-range points toggle pixels instead of setting them.
module coord_plotter #(
  parameter int FB_W  = 16,
  parameter int FB_H  = 16,
  parameter int CNT_W = 16
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  coord_plotter_if.slave          in_if,
  output logic                    _row_valid,
  output logic [$clog2(FB_H)-1:0] _row_index,
  output logic [FB_W-1:0]         _row_data,
  output logic [CNT_W-1:0]        _hit_count,
  output logic [CNT_W-1:0]        _clip_count,
  output logic                    _done
);
  localparam int RW = $clog2(FB_H);
  localparam int CW = $clog2(FB_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(FB_H - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCEPT, SCAN, DONE} state_e;

  state_e                      st_q, st_d;
  logic [FB_H-1:0][FB_W-1:0]   fb_q, fb_d;
  logic [RW-1:0]               cnt_q, cnt_d;
  logic                        in_ready_q, in_ready_d;
  logic                        row_valid_q, row_valid_d;
  logic [RW-1:0]               row_index_q, row_index_d;
  logic [FB_W-1:0]             row_data_q, row_data_d;
  logic [CNT_W-1:0]            hit_q, hit_d;
  logic [CNT_W-1:0]            clip_q, clip_d;
  logic                        done_q, done_d;

  logic          xfer;
  logic          in_rng;
  logic [RW-1:0] r_idx;
  logic [CW-1:0] c_idx;

  always_comb begin
    st_d        = st_q;
    fb_d        = fb_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    row_valid_d = row_valid_q;
    row_index_d = row_index_q;
    row_data_d  = row_data_q;
    hit_d       = hit_q;
    clip_d      = clip_q;
    done_d      = done_q;

    xfer   = in_if._in_valid & in_ready_q;
    in_rng = (in_if._in0 >= 0) && (in_if._in0 < FB_H) &&
             (in_if._in1 >= 0) && (in_if._in1 < FB_W);
    r_idx  = in_if._in0[RW-1:0];
    c_idx  = in_if._in1[CW-1:0];

    if (_start) begin
      st_d        = CLEAR;
      cnt_d       = '0;
      in_ready_d  = 1'b0;
      row_valid_d = 1'b0;
      row_index_d = '0;
      row_data_d  = '0;
      hit_d       = '0;
      clip_d      = '0;
      done_d      = 1'b0;
    end else begin
      case (st_q)
        CLEAR: begin
          fb_d[cnt_q] = '0;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == ROW_LAST) begin
            st_d       = ACCEPT;
            cnt_d      = '0;
            in_ready_d = 1'b1;
          end
        end
        ACCEPT: begin
          if (xfer) begin
            if (in_rng) begin
`ifdef COORD_PLOTTER_XOR_EN
              fb_d[r_idx][c_idx] = ~fb_q[r_idx][c_idx];
`else
              fb_d[r_idx][c_idx] = 1'b1;
`endif
              if (hit_q != '1) hit_d = hit_q + 1'b1;
            end else begin
              if (clip_q != '1) clip_d = clip_q + 1'b1;
            end
            // Row 0 is taken from fb_d so a pixel plotted by the last pair shows up.
            if (in_if._in_last) begin
              st_d        = SCAN;
              in_ready_d  = 1'b0;
              row_valid_d = 1'b1;
              row_index_d = '0;
              row_data_d  = fb_d[0];
            end
          end
        end
        SCAN: begin
          if (row_index_q == ROW_LAST) begin
            st_d        = DONE;
            row_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            row_index_d = row_index_q + 1'b1;
            row_data_d  = fb_q[row_index_q + 1'b1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      st_q        <= IDLE;
      fb_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      row_valid_q <= 1'b0;
      row_index_q <= '0;
      row_data_q  <= '0;
      hit_q       <= '0;
      clip_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      fb_q        <= fb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      row_valid_q <= row_valid_d;
      row_index_q <= row_index_d;
      row_data_q  <= row_data_d;
      hit_q       <= hit_d;
      clip_q      <= clip_d;
      done_q      <= done_d;
    end
  end

  assign in_if._in_ready = in_ready_q;
  assign _row_valid      = row_valid_q;
  assign _row_index      = row_index_q;
  assign _row_data       = row_data_q;
  assign _hit_count      = hit_q;
  assign _clip_count     = clip_q;
  assign _done           = done_q;
endmodule

// File: tb/tb_coord_plotter.sv
// Directed bench for coord_plotter: rectangle frame, clipping, re-frame and mid-scan reset.
module tb_coord_plotter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        row_valid;
  logic [3:0]  row_index;
  logic [15:0] row_data;
  logic [15:0] hit, clip;
  logic        done;
  logic [15:0] exp_rows [16];
  int          n_chk = 0;
  int          n_fail = 0;
  int          lowcnt;

  always #5 clk = ~clk;

  coord_plotter_if cif();

  coord_plotter #(.FB_W(16), .FB_H(16), .CNT_W(16)) dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start), .in_if(cif),
    ._row_valid(row_valid), ._row_index(row_index), ._row_data(row_data),
    ._hit_count(hit), ._clip_count(clip), ._done(done)
  );

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int r, int c, bit last, int gap);
    bit ok;
    cif._in_valid = 1'b0;
    repeat (gap) step();
    cif._in0 = r;
    cif._in1 = c;
    cif._in_last = last;
    cif._in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = cif._in_ready;
      step();
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    cif._in_valid = 1'b0;
    cif._in_last = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 16; k++) exp_rows[k] = 16'h0;
  endtask

  // Called in the first SCAN cycle; ends one cycle after the last row.
  task automatic scan_check(string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), {31'd0, row_valid}, 32'd1);
      chk($sformatf("%s_idx%0d", tag, k), {28'd0, row_index}, k);
      chk($sformatf("%s_row%0d", tag, k), {16'd0, row_data}, {16'd0, exp_rows[k]});
      step();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_valid_off"}, {31'd0, row_valid}, 32'd0);
  endtask

  initial begin
    cif._in_valid = 1'b0;
    cif._in0 = 0;
    cif._in1 = 0;
    cif._in_last = 1'b0;
    #12;
    chk("rst_ready", {31'd0, cif._in_ready}, 32'd0);
    chk("rst_row_valid", {31'd0, row_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_index", {28'd0, row_index}, 32'd0);
    chk("rst_data", {16'd0, row_data}, 32'd0);
    chk("rst_hit", {16'd0, hit}, 32'd0);
    chk("rst_clip", {16'd0, clip}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_ready", {31'd0, cif._in_ready}, 32'd0);

    // Frame 1: rectangle at (2,3) h=4 w=5, valid held from start.
    cif._in0 = 2;
    cif._in1 = 3;
    cif._in_valid = 1'b1;
    begin_frame();
    lowcnt = 0;
    while (!cif._in_ready && lowcnt < 100) begin
      lowcnt++;
      step();
    end
    chk("clear_ready_low", lowcnt, 32'd16);
    step();
    cif._in_valid = 1'b0;
    chk("first_xfer_hit", {16'd0, hit}, 32'd1);
    for (int c = 4; c <= 7; c++) send(2, c, 1'b0, $urandom_range(0, 2));
    for (int c = 3; c <= 7; c++) send(5, c, 1'b0, $urandom_range(0, 2));
    for (int r = 2; r <= 5; r++) send(r, 3, 1'b0, $urandom_range(0, 2));
    for (int r = 2; r <= 5; r++) send(r, 7, r == 5, $urandom_range(0, 2));
    chk("rect_ready_drop", {31'd0, cif._in_ready}, 32'd0);
    chk("rect_hit", {16'd0, hit}, 32'd18);
    chk("rect_clip", {16'd0, clip}, 32'd0);
    clear_exp();
`ifdef COORD_PLOTTER_XOR_EN
    exp_rows[2] = 16'h0070;
    exp_rows[5] = 16'h0070;
`else
    exp_rows[2] = 16'h00F8;
    exp_rows[5] = 16'h00F8;
`endif
    exp_rows[3] = 16'h0088;
    exp_rows[4] = 16'h0088;
    scan_check("rect");
    step();
    chk("rect_done_hold", {31'd0, done}, 32'd1);
    chk("rect_hit_hold", {16'd0, hit}, 32'd18);

    // Frame 2: clipping at each boundary.
    begin_frame();
    chk("f2_done_clr", {31'd0, done}, 32'd0);
    chk("f2_hit_clr", {16'd0, hit}, 32'd0);
    send(-1, 0, 1'b0, 0);
    send(16, 0, 1'b0, 1);
    send(0, 16, 1'b0, 0);
    send(0, 0, 1'b1, 2);
    chk("clip_clip", {16'd0, clip}, 32'd3);
    chk("clip_hit", {16'd0, hit}, 32'd1);
    clear_exp();
    exp_rows[0] = 16'h0001;
    scan_check("clip");

    // Frame 3: single point, counters restart.
    begin_frame();
    chk("f3_clip_clr", {16'd0, clip}, 32'd0);
    send(7, 7, 1'b1, 0);
    chk("f3_hit", {16'd0, hit}, 32'd1);
    chk("f3_clip", {16'd0, clip}, 32'd0);
    clear_exp();
    exp_rows[7] = 16'h0080;
    scan_check("pt");

    // Frame 4: reset during scan row 5.
    begin_frame();
    send(1, 1, 1'b1, 0);
    repeat (5) step();
    chk("rs_at_row5", {28'd0, row_index}, 32'd5);
    chk("rs_valid_pre", {31'd0, row_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", {31'd0, row_valid}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    chk("rs_hit", {16'd0, hit}, 32'd0);
    chk("rs_index", {28'd0, row_index}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (3) step();
    chk("rs_idle_ready", {31'd0, cif._in_ready}, 32'd0);
    chk("rs_idle_valid", {31'd0, row_valid}, 32'd0);
    chk("rs_idle_done", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/coord_plotter.md
Name: coord_plotter

Overview:
- Sink for the coordinate streams emitted by our generator modules (rectangle outlines, lines, circles), i.e. the consumer end of the (_out0, _out1) interface.
- Accepts signed (row, column) pairs with a valid/ready handshake, clips them to a fixed 1-bit framebuffer and sets the addressed pixels.
- On end-of-stream, scans the framebuffer out one row per cycle, then asserts _done.
- Used as the on-chip checker and display stage behind any generator.

Parameters:
- FB_W, 16, framebuffer width in pixels (columns); row data width.
- FB_H, 16, framebuffer height in pixels (rows).
- CNT_W, 16, width of the hit/clip counters.

Ports:
- _clock  input  1  sole clock, rising edge.
- _reset_n  input  1  asynchronous, active-low reset.
- _start  input  1  begin a new frame: clear, then accept.
- _in_valid  input  1  coordinate pair present.
- _in_ready  output  1  plotter can accept this cycle.
- _in0  input  32  signed row coordinate.
- _in1  input  32  signed column coordinate.
- _in_last  input  1  qualifies the final pair of the stream.
- _row_valid  output  1  scan-out row valid.
- _row_index  output  $clog2(FB_H)  scanned row number.
- _row_data  output  FB_W  row bitmap; bit c = column c.
- _hit_count  output  CNT_W  in-range pairs accepted.
- _clip_count  output  CNT_W  out-of-range pairs accepted.
- _done  output  1  frame complete.

Behaviour:
- Reset (async, _reset_n=0): state IDLE; framebuffer all 0; _in_ready, _row_valid, _done = 0; _row_index, _row_data, _hit_count, _clip_count = 0.
- States: IDLE, CLEAR, ACCEPT, SCAN, DONE.
- _start=1 in any state has top priority:
  - Next state is CLEAR; the row counter, both counters and _done are zeroed.
  - A handshake coinciding with _start is discarded.
- CLEAR:
  - Row r is zeroed in the r-th CLEAR cycle; FB_H cycles total, then ACCEPT.
  - _in_ready stays 0 throughout.
- ACCEPT:
  - _in_ready=1. A transfer occurs when _in_valid & _in_ready.
  - In range means 0 <= _in0 < FB_H and 0 <= _in1 < FB_W, using signed compare.
  - In range: set pixel (_in0, _in1) and increment _hit_count.
  - Out of range: framebuffer unchanged; increment _clip_count.
  - Both counters saturate at 2^CNT_W-1.
  - Duplicate pairs are legal, set an already-set pixel, and count again.
  - A transfer with _in_last=1 is plotted normally; the next state is SCAN and _in_ready drops in that next cycle.
- SCAN:
  - Row k is presented in the k-th SCAN cycle: _row_valid=1, _row_index=k, _row_data=row k.
  - There is no backpressure. After row FB_H-1 the next state is DONE.
  - A pixel written in the last ACCEPT cycle is visible in the scan.
- DONE:
  - _row_valid=0; _done=1, held until _start or reset.
  - Counters hold their final values.
- IDLE: _in_ready=0; waits for _start.
- Total frame latency: FB_H clear cycles + N accept cycles (minimum) + FB_H scan cycles.
- Reset asserted mid-frame (any state) returns to the reset values immediately; no partial scan continues.

Optional Feature:
- Macro: COORD_PLOTTER_XOR_EN.
- Defined: an in-range transfer toggles the pixel instead of setting it. Duplicate points cancel in pairs; counters are unchanged in behaviour.
- Undefined: set-only plotting as above.

Test Plan:
- Rectangle stream, row 2, col 3, height 4, width 5 (18 pairs; corners emitted twice; last flagged) -> rows 2 and 5 = 0x00F8, rows 3 and 4 = 0x0088, all other rows 0; _hit_count=18, _clip_count=0; _done one cycle after row 15.
- Same stream with COORD_PLOTTER_XOR_EN -> rows 2 and 5 = 0x0070, rows 3 and 4 = 0x0088; _hit_count=18.
- Pairs (-1,0), (16,0), (0,16), then (0,0) with last -> _clip_count=3, _hit_count=1, row 0 = 0x0001.
- Hold _in_valid=1 from _start -> _in_ready low for exactly 16 CLEAR cycles; first transfer in cycle 17; random ready/valid gaps lose no pair.
- Second frame: _start after _done, stream one pair (7,7) with last -> only row 7 = 0x0080; counters restarted at 0.
- Pull _reset_n low at scan row 5 -> _row_valid and _done immediately 0; after release, IDLE with _in_ready=0 until _start.
